instr_mem_responder: RTL and testbench

Synthesizable instruction-memory responder: the memory-side end of the core's instruction fetch interface (instr_req/instr_gnt/instr_rvalid/instr_rdata). It grants requests after a programmable delay, returns read data in order at a fixed latency, and limits outstanding transactions. It sits in place of the instruction memory so the IF tracking logic can be exercised against controllable grant and response timing.

---
 rtl/instr_mem_responder.sv | 136 +++++++++++++
 tb/tb_instr_mem_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Memory-side end of the instruction fetch interface: programmable grant delay,
// fixed-latency in-order responses, outstanding-request limit and a preloadable word store.
module instr_mem_responder #(
    parameter int INSTR_ADDR_WIDTH = 16,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int MEM_DEPTH_WORDS  = 1024,
    parameter int GNT_DELAY        = 0,
    parameter int RVALID_LATENCY   = 1,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_req,
    input  logic [INSTR_ADDR_WIDTH-1:0]   instr_addr,
    input  logic                          gnt_stall,
    output logic                          instr_gnt,
    output logic                          instr_rvalid,
    output logic [INSTR_DATA_WIDTH-1:0]   instr_rdata,
    output logic                          instr_err,
    output logic [3:0]                    outstanding,
    input  logic                          load_we,
    input  logic [INSTR_ADDR_WIDTH-3:0]   load_addr,
    input  logic [INSTR_DATA_WIDTH-1:0]   load_data
);

    localparam int WA = INSTR_ADDR_WIDTH - 2;
    localparam int MA = $clog2(MEM_DEPTH_WORDS);
    localparam logic [WA:0] DEPTH_C     = (WA + 1)'(MEM_DEPTH_WORDS);
    localparam logic [3:0]  GNT_DELAY_C = 4'(GNT_DELAY);
    localparam logic [3:0]  MAX_OUT_C   = 4'(MAX_OUTSTANDING);

    logic [INSTR_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

    logic [3:0]    wait_cnt;
    logic [4:0]    delay_diff;
    logic          delay_met;
    logic          slot_free;
    logic          handshake;
    logic [WA-1:0] req_word;
    logic          req_oor;
    logic          load_in_range;
    logic          tail_valid;
    logic [MA-1:0] tail_addr;
    logic          tail_oor;
    logic          unused_bits;

    assign req_word      = instr_addr[INSTR_ADDR_WIDTH-1:2];
    assign req_oor       = {1'b0, req_word} >= DEPTH_C;
    assign load_in_range = {1'b0, load_addr} < DEPTH_C;

    // Borrow-based compare keeps the test meaningful when GNT_DELAY is 0.
    assign delay_diff  = {1'b0, wait_cnt} - {1'b0, GNT_DELAY_C};
    assign delay_met   = ~delay_diff[4];
    assign unused_bits = ^{instr_addr[1:0], delay_diff[3:0]};

    assign slot_free = (outstanding < MAX_OUT_C) || instr_rvalid;
    assign instr_gnt = rst_n && instr_req && !gnt_stall && delay_met && slot_free;
    assign handshake = instr_req && instr_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!instr_req || handshake) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({handshake, instr_rvalid})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // The output register is the final latency stage, so only LATENCY-1 stages precede it.
    generate
        if (RVALID_LATENCY == 1) begin : g_direct
            assign tail_valid = handshake;
            assign tail_addr  = req_word[MA-1:0];
            assign tail_oor   = req_oor;
        end else begin : g_pipe
            localparam int PD = RVALID_LATENCY - 1;
            logic [PD-1:0] pipe_valid;
            logic [PD-1:0] pipe_oor;
            logic [MA-1:0] pipe_addr [PD];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_valid <= '0;
                    pipe_oor   <= '0;
                    for (int i = 0; i < PD; i++) pipe_addr[i] <= '0;
                end else begin
                    pipe_valid[0] <= handshake;
                    pipe_oor[0]   <= req_oor;
                    pipe_addr[0]  <= req_word[MA-1:0];
                    for (int i = 1; i < PD; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                        pipe_oor[i]   <= pipe_oor[i-1];
                        pipe_addr[i]  <= pipe_addr[i-1];
                    end
                end
            end

            assign tail_valid = pipe_valid[PD-1];
            assign tail_addr  = pipe_addr[PD-1];
            assign tail_oor   = pipe_oor[PD-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_rvalid <= 1'b0;
            instr_err    <= 1'b0;
            instr_rdata  <= '0;
        end else begin
            instr_rvalid <= tail_valid;
            instr_err    <= tail_valid && tail_oor;
            instr_rdata  <= (tail_valid && !tail_oor) ? mem[tail_addr] : '0;
        end
    end

    // Storage is not reset; a same-edge write is seen by the next read, not this one.
    always_ff @(posedge clk) begin
        if (load_we && load_in_range) begin
            mem[load_addr[MA-1:0]] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: four instances with different timing
// parameters share one stimulus stream; each check targets the instance under test.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req;
    logic [15:0] instr_addr;
    logic        gnt_stall;
    logic        load_we;
    logic [13:0] load_addr;
    logic [31:0] load_data;

    logic        gnt    [4];
    logic        rvalid [4];
    logic        err    [4];
    logic [31:0] rdata  [4];
    logic [3:0]  outst  [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // 0: defaults   1: GNT_DELAY=3   2: latency 4 / limit 2   3: latency 3 / limit 2
    instr_mem_responder u_def (
        .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_addr(instr_addr),
        .gnt_stall(gnt_stall), .instr_gnt(gnt[0]), .instr_rvalid(rvalid[0]),
        .instr_rdata(rdata[0]), .instr_err(err[0]), .outstanding(outst[0]),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

    instr_mem_responder #(.GNT_DELAY(3)) u_dly (
        .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_addr(instr_addr),
        .gnt_stall(gnt_stall), .instr_gnt(gnt[1]), .instr_rvalid(rvalid[1]),
        .instr_rdata(rdata[1]), .instr_err(err[1]), .outstanding(outst[1]),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

    instr_mem_responder #(.RVALID_LATENCY(4), .MAX_OUTSTANDING(2)) u_lat4 (
        .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_addr(instr_addr),
        .gnt_stall(gnt_stall), .instr_gnt(gnt[2]), .instr_rvalid(rvalid[2]),
        .instr_rdata(rdata[2]), .instr_err(err[2]), .outstanding(outst[2]),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

    instr_mem_responder #(.RVALID_LATENCY(3), .MAX_OUTSTANDING(2)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_addr(instr_addr),
        .gnt_stall(gnt_stall), .instr_gnt(gnt[3]), .instr_rvalid(rvalid[3]),
        .instr_rdata(rdata[3]), .instr_err(err[3]), .outstanding(outst[3]),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic load(input logic [13:0] a, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        next_cycle();
        load_we   = 1'b0;
    endtask

    initial begin
        instr_req  = 1'b0;
        instr_addr = '0;
        gnt_stall  = 1'b0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_data  = '0;

        vecs[0] = '{16'h0010, 32'h00A00093, 1'b0};
        vecs[1] = '{16'h0013, 32'h00A00093, 1'b0};
        vecs[2] = '{16'h0004, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{16'h0000, 32'h00000013, 1'b0};
        vecs[4] = '{16'h0FFC, 32'hCAFEF00D, 1'b0};
        vecs[5] = '{16'h1000, 32'h00000000, 1'b1};
        vecs[6] = '{16'hFFFC, 32'h00000000, 1'b1};
        vecs[7] = '{16'h0020, 32'h11111111, 1'b0};

        // Reset values, with a request pending to show the grant is held off
        repeat (3) @(posedge clk);
        #1;
        instr_req = 1'b1;
        settle();
        chk("rst_gnt", gnt[0], 0);
        chk("rst_rvalid", rvalid[0], 0);
        chk("rst_rdata", rdata[0], 0);
        chk("rst_err", err[0], 0);
        chk("rst_outst", outst[0], 0);
        instr_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;

        load(14'd0, 32'h00000013);
        load(14'd1, 32'hDEADBEEF);
        load(14'd2, 32'h00000202);
        load(14'd4, 32'h00A00093);
        load(14'd8, 32'h11111111);
        load(14'd1023, 32'hCAFEF00D);

        // Single fetch
        instr_req = 1'b1;
        instr_addr = 16'h0010;
        settle();
        chk("single_gnt", gnt[0], 1);
        chk("single_outst0", outst[0], 0);
        next_cycle();
        instr_req = 1'b0;
        settle();
        chk("single_rvalid", rvalid[0], 1);
        chk("single_rdata", rdata[0], 32'h00A00093);
        chk("single_outst1", outst[0], 1);
        next_cycle();
        settle();
        chk("single_outst2", outst[0], 0);
        chk("single_idle_rvalid", rvalid[0], 0);
        chk("single_idle_rdata", rdata[0], 0);
        next_cycle();

        // Table of single fetches, including ignored low bits and out-of-range words
        for (int i = 0; i < 8; i++) begin
            instr_req = 1'b1;
            instr_addr = vecs[i].addr;
            settle();
            chk($sformatf("vec%0d_gnt", i), gnt[0], 1);
            next_cycle();
            instr_req = 1'b0;
            settle();
            chk($sformatf("vec%0d_rvalid", i), rvalid[0], 1);
            chk($sformatf("vec%0d_rdata", i), rdata[0], vecs[i].data);
            chk($sformatf("vec%0d_err", i), err[0], {31'b0, vecs[i].err});
            next_cycle();
            settle();
            chk($sformatf("vec%0d_idle_rvalid", i), rvalid[0], 0);
            chk($sformatf("vec%0d_idle_rdata", i), rdata[0], 0);
            chk($sformatf("vec%0d_idle_err", i), err[0], 0);
            next_cycle();
        end

        // Stall hook holds off the grant
        instr_req = 1'b1;
        instr_addr = 16'h0000;
        gnt_stall = 1'b1;
        settle();
        chk("stall_gnt_a", gnt[0], 0);
        next_cycle();
        settle();
        chk("stall_gnt_b", gnt[0], 0);
        chk("stall_rvalid", rvalid[0], 0);
        next_cycle();
        gnt_stall = 1'b0;
        settle();
        chk("stall_release_gnt", gnt[0], 1);
        next_cycle();
        instr_req = 1'b0;
        settle();
        chk("stall_rvalid_after", rvalid[0], 1);
        chk("stall_rdata_after", rdata[0], 32'h00000013);
        next_cycle();
        repeat (10) next_cycle();

        // Grant delay of 3, then back-to-back restart of the delay
        instr_req = 1'b1;
        instr_addr = 16'h0004;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("dly_c%0d_gnt", c), gnt[1], 0);
            next_cycle();
        end
        settle();
        chk("dly_c3_gnt", gnt[1], 1);
        next_cycle();
        settle();
        chk("dly_c4_rvalid", rvalid[1], 1);
        chk("dly_c4_rdata", rdata[1], 32'hDEADBEEF);
        chk("dly_c4_gnt", gnt[1], 0);
        next_cycle();
        for (int c = 5; c < 7; c++) begin
            settle();
            chk($sformatf("dly_c%0d_gnt", c), gnt[1], 0);
            next_cycle();
        end
        settle();
        chk("dly_c7_gnt", gnt[1], 1);
        next_cycle();
        instr_req = 1'b0;
        settle();
        chk("dly_c8_rvalid", rvalid[1], 1);
        next_cycle();
        repeat (10) next_cycle();

        // Outstanding limit with latency 4
        instr_req = 1'b1;
        instr_addr = 16'h0000;
        settle();
        chk("lim_c0_gnt", gnt[2], 1);
        next_cycle();
        instr_addr = 16'h0004;
        settle();
        chk("lim_c1_gnt", gnt[2], 1);
        chk("lim_c1_outst", outst[2], 1);
        next_cycle();
        instr_addr = 16'h0008;
        settle();
        chk("lim_c2_gnt", gnt[2], 0);
        chk("lim_c2_outst", outst[2], 2);
        next_cycle();
        settle();
        chk("lim_c3_gnt", gnt[2], 0);
        chk("lim_c3_rvalid", rvalid[2], 0);
        next_cycle();
        settle();
        chk("lim_c4_gnt", gnt[2], 1);
        chk("lim_c4_rvalid", rvalid[2], 1);
        chk("lim_c4_rdata", rdata[2], 32'h00000013);
        next_cycle();
        instr_req = 1'b0;
        settle();
        chk("lim_c5_rvalid", rvalid[2], 1);
        chk("lim_c5_rdata", rdata[2], 32'hDEADBEEF);
        chk("lim_c5_outst", outst[2], 2);
        next_cycle();
        settle();
        chk("lim_c6_rvalid", rvalid[2], 0);
        chk("lim_c6_outst", outst[2], 1);
        next_cycle();
        settle();
        chk("lim_c7_rvalid", rvalid[2], 0);
        next_cycle();
        settle();
        chk("lim_c8_rvalid", rvalid[2], 1);
        chk("lim_c8_rdata", rdata[2], 32'h00000202);
        next_cycle();
        settle();
        chk("lim_c9_outst", outst[2], 0);
        next_cycle();
        repeat (10) next_cycle();

        // Write/read collision on word 8
        instr_req = 1'b1;
        instr_addr = 16'h0020;
        load_we = 1'b1;
        load_addr = 14'd8;
        load_data = 32'h22222222;
        settle();
        chk("coll_gnt", gnt[0], 1);
        next_cycle();
        instr_req = 1'b0;
        load_we = 1'b0;
        settle();
        chk("coll_rvalid", rvalid[0], 1);
        chk("coll_old_data", rdata[0], 32'h11111111);
        next_cycle();
        instr_req = 1'b1;
        settle();
        next_cycle();
        instr_req = 1'b0;
        settle();
        chk("coll_new_data", rdata[0], 32'h22222222);
        next_cycle();
        repeat (10) next_cycle();

        // Reset with two grants in flight (latency 3)
        instr_req = 1'b1;
        instr_addr = 16'h0000;
        settle();
        chk("mid_c0_gnt", gnt[3], 1);
        next_cycle();
        instr_addr = 16'h0004;
        settle();
        chk("mid_c1_gnt", gnt[3], 1);
        next_cycle();
        #2;
        rst_n = 1'b0;
        settle();
        chk("mid_rst_gnt", gnt[3], 0);
        chk("mid_rst_rvalid", rvalid[3], 0);
        chk("mid_rst_rdata", rdata[3], 0);
        chk("mid_rst_err", err[3], 0);
        chk("mid_rst_outst", outst[3], 0);
        instr_req = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("post_rst_c%0d_rvalid", c), rvalid[3], 0);
            chk($sformatf("post_rst_c%0d_outst", c), outst[3], 0);
            next_cycle();
        end
        instr_req = 1'b1;
        instr_addr = 16'h0004;
        settle();
        chk("post_rst_gnt", gnt[3], 1);
        next_cycle();
        instr_req = 1'b0;
        settle();
        chk("post_rst_h1_rvalid", rvalid[3], 0);
        next_cycle();
        next_cycle();
        settle();
        chk("post_rst_rvalid", rvalid[3], 1);
        chk("post_rst_mem_kept", rdata[3], 32'hDEADBEEF);
        next_cycle();

        // Grant in the reset release cycle
        rst_n = 1'b0;
        next_cycle();
        #1;
        rst_n = 1'b1;
        instr_req = 1'b1;
        instr_addr = 16'h0020;
        settle();
        chk("release_gnt", gnt[0], 1);
        next_cycle();
        instr_req = 1'b0;
        settle();
        chk("release_rvalid", rvalid[0], 1);
        chk("release_rdata", rdata[0], 32'h22222222);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
